// File: rtl/pb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pb_arbiter                                                 |
// | Description : Round-robin arbiter for 16 asynchronous push-button        |
// |               requests. Each request is synchronized, rising-edge        |
// |               detected and latched into a sticky pending register; a     |
// |               two-state FSM offers one grant at a time until ack.        |
// |               Optional grant timeout enabled by macro PB_ARB_TIMEOUT_EN. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pb_arbiter #(
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        ack,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic [15:0] pending,
  output logic        timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_dly;
  logic [15:0] w_rise;
  logic [3:0]  r_last_idx;
  logic [3:0]  w_last_idx_next;
  logic [15:0] w_clear;
  logic [15:0] w_pending_next;
  logic        w_grant_valid_next;
  logic [3:0]  w_grant_idx_next;
  logic [15:0] w_onehot_next;
  logic        w_timeout_next;
  logic        w_sel_found;
  logic [3:0]  w_sel_idx;
  logic        w_expire;

  // Two-flop synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge hz100) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
    end else begin
      r_sync1 <= req;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_dly;

  // Round-robin search: first pending bit upward from last_idx+1, wrapping
  always_comb begin
    logic [3:0] cand;
    w_sel_found = 1'b0;
    w_sel_idx   = r_last_idx;
    cand        = '0;
    for (int k = 1; k <= 16; k++) begin
      cand = r_last_idx + 4'(k);
      if (!w_sel_found && pending[cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = cand;
      end
    end
  end

`ifdef PB_ARB_TIMEOUT_EN
  localparam logic [7:0] c_timeout_limit = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_cnt;

  // Grant age counter: zero while idle so every grant starts from zero
  always_ff @(posedge hz100) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == GRANT) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_expire = (r_state == GRANT) && ((r_cnt + 8'd1) == c_timeout_limit);
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign w_expire              = 1'b0;
`endif

  // Next-state and next-output logic; a grant ends on ack or expiry,
  // and ack on the expiry edge suppresses the timeout pulse
  always_comb begin
    w_state_next       = r_state;
    w_last_idx_next    = r_last_idx;
    w_clear            = '0;
    w_grant_valid_next = grant_valid;
    w_grant_idx_next   = grant_idx;
    w_onehot_next      = grant_onehot;
    w_timeout_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_state_next       = GRANT;
          w_grant_valid_next = 1'b1;
          w_grant_idx_next   = w_sel_idx;
          w_onehot_next      = 16'h0001 << w_sel_idx;
        end
      end
      GRANT: begin
        if (ack || w_expire) begin
          w_state_next       = IDLE;
          w_clear            = grant_onehot;
          w_last_idx_next    = grant_idx;
          w_grant_valid_next = 1'b0;
          w_onehot_next      = '0;
          w_timeout_next     = ~ack;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A new rising edge wins over a clear on the same bit
    w_pending_next = (pending & ~w_clear) | w_rise;
  end

  // State and registered outputs
  always_ff @(posedge hz100) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_idx   <= 4'hF;
      pending      <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_idx   <= w_last_idx_next;
      pending      <= w_pending_next;
      grant_valid  <= w_grant_valid_next;
      grant_idx    <= w_grant_idx_next;
      grant_onehot <= w_onehot_next;
      timeout      <= w_timeout_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pb_arbiter                                              |
// | Description : Self-checking bench for pb_arbiter: vector table, directed |
// |               corner sequences and random traffic against a reference   |
// |               model. Honours PB_ARB_TIMEOUT_EN like the design.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pb_arbiter;

  localparam int TO = 4;
`ifdef PB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        hz100;
  logic        reset;
  logic [15:0] req;
  logic        ack;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic [15:0] pending;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  pb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .pending     (pending),
    .timeout     (timeout)
  );

  initial begin
    hz100 = 1'b0;
    forever #5 hz100 = ~hz100;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // hist[0] is the newest req sample; a bit becomes pending two edges after
  // the first sample at which it was seen high following a low sample.
  logic [15:0] hist[$];
  logic [15:0] m_pend;
  bit          m_busy;
  int          m_gidx;
  int          m_last;
  int          m_age;
  bit          m_to;

  task automatic model_edge();
    logic [15:0] rise;
    logic [15:0] clr;
    if (reset) begin
      hist   = '{16'h0, 16'h0, 16'h0};
      m_pend = '0;
      m_busy = 1'b0;
      m_gidx = 0;
      m_last = 15;
      m_age  = 0;
      m_to   = 1'b0;
    end else begin
      hist.push_front(req);
      rise = hist[2] & ~hist[3];
      while (hist.size() > 4) void'(hist.pop_back());
      clr  = '0;
      m_to = 1'b0;
      if (!m_busy) begin
        for (int k = 1; k <= 16; k++) begin
          int c;
          c = (m_last + k) % 16;
          if (!m_busy && m_pend[c]) begin
            m_gidx = c;
            m_busy = 1'b1;
            m_age  = 0;
          end
        end
      end else begin
        m_age++;
        if (ack) begin
          clr[m_gidx] = 1'b1;
          m_last = m_gidx;
          m_busy = 1'b0;
        end else if (TO_EN && m_age == TO) begin
          clr[m_gidx] = 1'b1;
          m_last = m_gidx;
          m_busy = 1'b0;
          m_to   = 1'b1;
        end
      end
      m_pend = (m_pend & ~clr) | rise;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven, model advances at the edge, outputs
  // are compared at the following falling edge.
  task automatic step();
    @(posedge hz100);
    model_edge();
    @(negedge hz100);
    chk("model_grant_valid", 32'(grant_valid), 32'(m_busy));
    if (m_busy) chk("model_grant_idx", 32'(grant_idx), 32'(m_gidx));
    chk("model_grant_onehot", 32'(grant_onehot), m_busy ? (32'd1 << m_gidx) : 32'd0);
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int got[$];

  // Run a number of cycles holding req, acking every offered grant at once
  task automatic collect(input int cycles, input logic [15:0] r);
    got.delete();
    for (int i = 0; i < cycles; i++) begin
      if (grant_valid) begin
        got.push_back(int'(grant_idx));
        ack = 1'b1;
      end else begin
        ack = 1'b0;
      end
      req = r;
      step();
    end
    ack = 1'b0;
  endtask

  task automatic wait_grant(input logic [15:0] r, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (grant_valid) break;
      req = r; ack = 1'b0;
      step();
    end
    chk("wait_grant_bound", 32'(grant_valid), 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] r;
    logic        a;
    logic        gv;
    logic [3:0]  idx;
    logic [15:0] pend;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int hi_cnt;
    int to_cnt;
    logic [15:0] oh;

    // single request: reset, edge-4 latency, ack, release
    tbl[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000};
    tbl[1] = '{1'b0, 16'h0020, 1'b0, 1'b0, 4'd0, 16'h0000};
    tbl[2] = '{1'b0, 16'h0020, 1'b0, 1'b0, 4'd0, 16'h0000};
    tbl[3] = '{1'b0, 16'h0020, 1'b0, 1'b0, 4'd0, 16'h0020};
    tbl[4] = '{1'b0, 16'h0020, 1'b0, 1'b1, 4'd5, 16'h0020};
    tbl[5] = '{1'b0, 16'h0020, 1'b1, 1'b0, 4'd0, 16'h0000};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000};

    reset = 1'b1; req = '0; ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst; req = tbl[i].r; ack = tbl[i].a;
      step();
      chk($sformatf("tbl%0d_grant_valid", i), 32'(grant_valid), 32'(tbl[i].gv));
      if (tbl[i].gv || tbl[i].rst)
        chk($sformatf("tbl%0d_grant_idx", i), 32'(grant_idx), 32'(tbl[i].idx));
      oh = tbl[i].gv ? (16'h0001 << tbl[i].idx) : 16'h0000;
      chk($sformatf("tbl%0d_grant_onehot", i), 32'(grant_onehot), 32'(oh));
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // simultaneous requests 0, 3, 15 granted in order
    do_reset();
    collect(20, 16'h8009);
    chk("order3_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("order3_first", 32'(got[0]), 32'd0);
      chk("order3_second", 32'(got[1]), 32'd3);
      chk("order3_third", 32'(got[2]), 32'd15);
    end

    // round-robin wrap after granting 3
    do_reset();
    collect(10, 16'h0008);
    chk("rr_pre_count", 32'(got.size()), 32'd1);
    collect(20, 16'h0082);
    chk("rr_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("rr_first", 32'(got[0]), 32'd7);
      chk("rr_second", 32'(got[1]), 32'd1);
    end

    // set wins over clear when a new edge on the granted bit meets ack
    do_reset();
    req = 16'h0040; step();
    req = 16'h0000; step();
    step();
    req = 16'h0040; step();
    chk("setwin_grant_valid", 32'(grant_valid), 32'd1);
    chk("setwin_grant_idx", 32'(grant_idx), 32'd6);
    req = 16'h0000; step();
    ack = 1'b1; step();
    ack = 1'b0;
    chk("setwin_released", 32'(grant_valid), 32'd0);
    chk("setwin_pending", 32'(pending), 32'h0040);
    step();
    chk("setwin_regrant", 32'(grant_valid), 32'd1);
    chk("setwin_regrant_idx", 32'(grant_idx), 32'd6);
    ack = 1'b1; step();
    ack = 1'b0;

    // reset mid-grant, then search restarts from index 0
    do_reset();
    collect(10, 16'h1000);
    chk("rst_pre_count", 32'(got.size()), 32'd1);
    wait_grant(16'h0150, 12);
    chk("rst_pre_idx", 32'(grant_idx), 32'd4);
    chk("rst_pre_pending", 32'(pending), 32'h0150);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    collect(20, 16'h4004);
    chk("rst_post_count", 32'(got.size()), 32'd2);
    if (got.size() > 0) chk("rst_post_first", 32'(got[0]), 32'd2);

`ifdef PB_ARB_TIMEOUT_EN
    // unacknowledged grant expires after TO cycles
    do_reset();
    wait_grant(16'h0020, 10);
    hi_cnt = 1;
    for (int i = 0; i < 50; i++) begin
      if (!grant_valid) break;
      req = 16'h0020; ack = 1'b0;
      step();
      if (grant_valid) hi_cnt++;
    end
    chk("to_grant_cycles", 32'(hi_cnt), 32'(TO));
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_pending_cleared", 32'(pending), 32'd0);
    step();
    chk("to_pulse_end", 32'(timeout), 32'd0);
`else
    // repeated pulses during a grant coalesce into one pending bit
    do_reset();
    wait_grant(16'h0200, 10);
    for (int p = 0; p < 3; p++) begin
      req = 16'h0204; step();
      req = 16'h0200; step();
      step();
    end
    step();
    chk("coal_grant_held", 32'(grant_valid), 32'd1);
    chk("coal_grant_idx", 32'(grant_idx), 32'd9);
    chk("coal_pending", 32'(pending), 32'h0204);
    collect(20, 16'h0200);
    chk("coal_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("coal_first", 32'(got[0]), 32'd9);
      chk("coal_second", 32'(got[1]), 32'd2);
    end

    // no timeout: grant held for 1000 cycles
    do_reset();
    wait_grant(16'h0020, 10);
    hi_cnt = 0;
    to_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      req = 16'h0020; ack = 1'b0;
      step();
      if (grant_valid) hi_cnt++;
      if (timeout) to_cnt++;
    end
    chk("hold_cycles", 32'(hi_cnt), 32'd1000);
    chk("hold_no_timeout", 32'(to_cnt), 32'd0);
    ack = 1'b1; step();
    ack = 1'b0;
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      req   = req ^ 16'($urandom & $urandom & $urandom);
      ack   = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
